// File: rtl/melody_player.sv
// Buzzer melody sequencer: walks {dur, pitch} words from a synchronous note ROM,
// turns each pitch into a square wave and leaves a silent articulation gap per note.
module melody_player #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 16,
  parameter int ADDR_W    = 8,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 4,
  parameter int DIV_W     = 18,
  parameter int GAP_TICKS = 1
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       start_addr,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DUR_W+NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       pitch,
  input  logic [DIV_W-1:0]        half_period,
  output logic                    speaker,
  output logic                    busy,
  output logic                    note_strobe,
  output logic                    done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [DUR_W-1:0]  dur;
  logic [DUR_W-1:0]  ticks;
  logic [PRE_W-1:0]  pre;
  logic [DIV_W-1:0]  tone_cnt;

  logic [DUR_W-1:0]  rom_dur;
  logic [NOTE_W-1:0] rom_pitch;
  logic              tick_end;
  logic [DUR_W:0]    ticks_nxt;
  logic [DUR_W:0]    gap_at;
  logic              has_gap;
  logic              silent;

  assign rom_dur   = rom_data[DUR_W+NOTE_W-1:NOTE_W];
  assign rom_pitch = rom_data[NOTE_W-1:0];
  assign busy      = (state != S_IDLE);
  assign tick_end  = (pre == PRE_W'(TICK_DIV - 1));
  assign ticks_nxt = {1'b0, ticks} + (DUR_W+1)'(1);
  assign gap_at    = {1'b0, dur} - (DUR_W+1)'(GAP_TICKS);
  // Notes no longer than the gap play for their whole duration with no silence.
  assign has_gap   = (GAP_TICKS > 0) && ({1'b0, dur} > (DUR_W+1)'(GAP_TICKS));
  assign silent    = (pitch == '0) || (half_period < DIV_W'(2));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      base        <= '0;
      rom_addr    <= '0;
      pitch       <= '0;
      dur         <= '0;
      ticks       <= '0;
      pre         <= '0;
      tone_cnt    <= '0;
      speaker     <= 1'b0;
      note_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      done        <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        speaker <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              base     <= start_addr;
              rom_addr <= start_addr;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            if (rom_dur == '0) begin
              if (loop_en) begin
                rom_addr <= base;
                state    <= S_FETCH;
              end else begin
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end else begin
              dur         <= rom_dur;
              pitch       <= rom_pitch;
              pre         <= '0;
              ticks       <= '0;
              tone_cnt    <= '0;
              speaker     <= 1'b0;
              note_strobe <= 1'b1;
              state       <= S_PLAY;
            end
          end
          S_PLAY: begin
            pre <= tick_end ? '0 : pre + PRE_W'(1);
            if (tick_end) ticks <= ticks_nxt[DUR_W-1:0];
            if (silent) begin
              tone_cnt <= '0;
              speaker  <= 1'b0;
            end else if (tone_cnt == half_period - DIV_W'(1)) begin
              tone_cnt <= '0;
              speaker  <= ~speaker;
            end else begin
              tone_cnt <= tone_cnt + DIV_W'(1);
            end
            // Leaving PLAY overrides any toggle on the same edge.
            if (tick_end && has_gap && ticks_nxt == gap_at) begin
              state   <= S_GAP;
              speaker <= 1'b0;
            end else if (tick_end && !has_gap && ticks_nxt == {1'b0, dur}) begin
              state    <= S_FETCH;
              rom_addr <= rom_addr + ADDR_W'(1);
              speaker  <= 1'b0;
            end
          end
          S_GAP: begin
            speaker <= 1'b0;
            pre     <= tick_end ? '0 : pre + PRE_W'(1);
            if (tick_end) begin
              ticks <= ticks_nxt[DUR_W-1:0];
              if (ticks_nxt == {1'b0, dur}) begin
                state    <= S_FETCH;
                rom_addr <= rom_addr + ADDR_W'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: directed and random songs checked cycle by cycle against
// a timeline built from the note list (fetch/wait overhead, tone phase, gap tail).
module tb_melody_player;
  localparam int TD   = 10;
  localparam int G    = 1;
  localparam int MAXL = 512;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        start, stop, loop_en;
  logic [7:0]  start_addr;
  logic [7:0]  rom_addr;
  logic [9:0]  rom_data;
  logic [5:0]  pitch;
  logic [17:0] half_period;
  logic        speaker, busy, note_strobe, done;

  logic [9:0]  rom [256];
  logic [17:0] hp_tab [64];

  int pass_cnt = 0;
  int total_cnt = 0;

  bit         e_spk [MAXL];
  bit         e_busy[MAXL];
  bit         e_stb [MAXL];
  bit         e_done[MAXL];
  bit         e_av  [MAXL];
  logic [7:0] e_addr[MAXL];
  logic [5:0] e_pitch[MAXL];

  melody_player #(
    .CLK_HZ(1000), .TICK_HZ(100), .ADDR_W(8), .NOTE_W(6),
    .DUR_W(4), .DIV_W(18), .GAP_TICKS(G)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .pitch(pitch), .half_period(half_period), .speaker(speaker), .busy(busy),
    .note_strobe(note_strobe), .done(done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) rom_data <= rom[rom_addr];
  assign half_period = hp_tab[pitch];

  task automatic check(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s @%0d: got %0h expected %0h", tag, t, got, exp);
  endtask

  // Expected timeline; index 0 is the first cycle after start is sampled.
  task automatic build(input int sa, input bit lp, input int len, output int L);
    int t, a, d, p, hp, ps, playlen;
    for (int i = 0; i < MAXL; i++) begin
      e_spk[i] = 0; e_busy[i] = 0; e_stb[i] = 0; e_done[i] = 0; e_av[i] = 0;
      e_addr[i] = '0; e_pitch[i] = '0;
    end
    t = 0; a = sa;
    while (1) begin
      if (t >= len) begin L = len; return; end
      e_busy[t] = 1; e_busy[t+1] = 1; e_av[t] = 1; e_addr[t] = 8'(a);
      d = int'(rom[a][9:6]); p = int'(rom[a][5:0]); hp = int'(hp_tab[p]);
      if (d == 0) begin
        if (lp) begin a = sa; t += 2; continue; end
        e_done[t+2] = 1; L = t + 4; return;
      end
      ps = t + 2;
      e_stb[ps] = 1; e_pitch[ps] = 6'(p);
      playlen = ((d > G) ? d - G : d) * TD;
      for (int k = 0; k < d * TD; k++) begin
        if (ps + k < MAXL) begin
          e_busy[ps+k] = 1;
          e_spk[ps+k]  = (k < playlen && p != 0 && hp >= 2) ? bit'((k / hp) % 2) : 1'b0;
        end
      end
      t = ps + d * TD; a = (a + 1) % 256;
    end
  endtask

  task automatic run_song(input string tag, input int sa, input bit lp, input int len, input int inj);
    int L;
    build(sa, lp, len, L);
    loop_en = lp; start_addr = 8'(sa); start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int t = 0; t < L; t++) begin
      check({tag, ".speaker"}, t, 32'(speaker), 32'(e_spk[t]));
      check({tag, ".busy"}, t, 32'(busy), 32'(e_busy[t]));
      check({tag, ".strobe"}, t, 32'(note_strobe), 32'(e_stb[t]));
      check({tag, ".done"}, t, 32'(done), 32'(e_done[t]));
      if (e_av[t]) check({tag, ".rom_addr"}, t, 32'(rom_addr), 32'(e_addr[t]));
      if (e_stb[t]) check({tag, ".pitch"}, t, 32'(pitch), 32'(e_pitch[t]));
      if (t == inj) begin start_addr = ~8'(sa); start = 1'b1; end
      @(negedge sys_clk);
      start = 1'b0;
    end
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    check({tag, ".busy"}, 0, 32'(busy), 32'd0);
    check({tag, ".speaker"}, 0, 32'(speaker), 32'd0);
    check({tag, ".done"}, 0, 32'(done), 32'd0);
    @(negedge sys_clk);
    check({tag, ".done2"}, 1, 32'(done), 32'd0);
    check({tag, ".busy2"}, 1, 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rom_addr"}, 0, 32'(rom_addr), 32'd0);
    check({tag, ".pitch"}, 0, 32'(pitch), 32'd0);
    check({tag, ".speaker"}, 0, 32'(speaker), 32'd0);
    check({tag, ".busy"}, 0, 32'(busy), 32'd0);
    check({tag, ".strobe"}, 0, 32'(note_strobe), 32'd0);
    check({tag, ".done"}, 0, 32'(done), 32'd0);
  endtask

  initial begin
    int sa, n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; start_addr = '0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 64; i++) hp_tab[i] = 18'($urandom_range(0, 9));
    hp_tab[5] = 18'd4;
    hp_tab[1] = 18'd1;
    repeat (3) @(negedge sys_clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge sys_clk);

    // Single note {3,5}, then end marker.
    rom[0] = {4'd3, 6'd5}; rom[1] = '0;
    run_song("basic", 0, 1'b0, MAXL, -1);

    // Same song looping: strobes every 34 cycles, never done.
    run_song("loop", 0, 1'b1, 150, -1);
    do_stop("loop_stop");

    // Rest note.
    rom[0] = {4'd2, 6'd0};
    run_song("rest", 0, 1'b0, MAXL, -1);

    // Address wrap 255 -> 0.
    rom[255] = {4'd1, 6'd5}; rom[0] = '0;
    run_song("wrap", 255, 1'b0, MAXL, -1);

    // Stop mid-PLAY while the tone is running.
    rom[0] = {4'd3, 6'd5}; rom[1] = '0;
    start_addr = 8'd0; loop_en = 1'b0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (7) @(negedge sys_clk);
    check("midplay.busy", 7, 32'(busy), 32'd1);
    check("midplay.speaker", 7, 32'(speaker), 32'd1);
    do_stop("midplay_stop");

    // Start and stop together from IDLE: nothing happens.
    start_addr = 8'h77; start = 1'b1; stop = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; stop = 1'b0;
    check("startstop.busy", 0, 32'(busy), 32'd0);
    check("startstop.rom_addr", 0, 32'(rom_addr), 32'd0);
    check("startstop.done", 0, 32'(done), 32'd0);

    // Start pulse while busy must be ignored.
    rom[8'h30] = {4'd2, 6'd5}; rom[8'h31] = {4'd1, 6'd3}; rom[8'h32] = '0;
    run_song("busystart", 8'h30, 1'b0, MAXL, 5);

    // Asynchronous reset in the middle of a tone.
    rom[0] = {4'd6, 6'd5}; rom[1] = '0;
    start_addr = 8'd0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 0; i < 50 && speaker !== 1'b1; i++) @(negedge sys_clk);
    check("prerst.speaker", 0, 32'(speaker), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    rom[8'h40] = {4'd2, 6'd5}; rom[8'h41] = '0;
    run_song("after_rst", 8'h40, 1'b0, MAXL, -1);

    // Random songs.
    for (int it = 0; it < 8; it++) begin
      sa = int'($urandom_range(0, 255));
      n  = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++)
        rom[(sa + j) % 256] = {4'($urandom_range(1, 3)), 6'($urandom_range(0, 7))};
      rom[(sa + n) % 256] = '0;
      run_song("rnd", sa, 1'b0, MAXL, (it % 2) ? 6 : -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
